// File: rtl/jpeg_huff_pkg.sv
// Shared JPEG Huffman constants and helpers for the DC (and later AC) entropy coders.
package jpeg_huff_pkg;

    localparam int unsigned DC_CAT_MAX = 11;
    localparam int unsigned DC_AMP_MAX = 2047;
    localparam int unsigned CAT_W      = 4;
    localparam int unsigned AMP_W      = 11;
    localparam int unsigned VAL_W      = AMP_W + 1;
    localparam int unsigned CODE_W     = 16;
    localparam int unsigned LEN_W      = 5;

    localparam logic [CODE_W-1:0] LUMA_DC_CODE [DC_CAT_MAX+1] = '{
        16'h0000, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006,
        16'h000E, 16'h001E, 16'h003E, 16'h007E, 16'h00FE, 16'h01FE
    };
    localparam logic [LEN_W-1:0] LUMA_DC_LEN [DC_CAT_MAX+1] = '{
        5'd2, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9
    };
    localparam logic [CODE_W-1:0] CHROMA_DC_CODE [DC_CAT_MAX+1] = '{
        16'h0000, 16'h0001, 16'h0002, 16'h0006, 16'h000E, 16'h001E,
        16'h003E, 16'h007E, 16'h00FE, 16'h01FE, 16'h03FE, 16'h07FE
    };
    localparam logic [LEN_W-1:0] CHROMA_DC_LEN [DC_CAT_MAX+1] = '{
        5'd2, 5'd2, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11
    };

    // Size category: bit length of the magnitude, 0 for a zero magnitude.
    function automatic logic [CAT_W-1:0] dc_category(input logic [AMP_W-1:0] mag);
        logic [CAT_W-1:0] cat;
        cat = '0;
        for (int i = 0; i < int'(AMP_W); i++) begin
            if (mag[i]) cat = CAT_W'(i + 1);
        end
        return cat;
    endfunction

    // Negative values send the low bits of (v-1), i.e. the ones complement of |v|.
    function automatic logic [AMP_W-1:0] dc_amp_bits(input logic signed [VAL_W-1:0] v,
                                                     input logic [CAT_W-1:0] cat);
        logic [VAL_W-1:0] raw;
        logic [VAL_W-1:0] mask;
        raw  = v[VAL_W-1] ? VAL_W'(v - VAL_W'(1)) : VAL_W'(v);
        mask = (VAL_W'(1) << cat) - VAL_W'(1);
        return raw[AMP_W-1:0] & mask[AMP_W-1:0];
    endfunction

endpackage

// File: rtl/dc_category_huff.sv
// Combinational clamp, size categorisation and DC Huffman lookup for one difference value.
module dc_category_huff
    import jpeg_huff_pkg::*;
#(
    parameter int unsigned DIFF_W = 13
) (
    input  logic signed [DIFF_W-1:0] diff_i,
    input  logic                     is_luma_i,
    output logic [CODE_W-1:0]        huff_code_o,
    output logic [LEN_W-1:0]         huff_len_o,
    output logic [AMP_W-1:0]         amp_bits_o,
    output logic [CAT_W-1:0]         amp_len_o,
    output logic                     sat_o
);

    localparam logic signed [DIFF_W-1:0] AMP_MAX_S = DIFF_W'(DC_AMP_MAX);

    logic signed [DIFF_W-1:0] clamped;
    logic signed [VAL_W-1:0]  val;
    logic [AMP_W-1:0]         mag;
    logic [CAT_W-1:0]         cat;

    always_comb begin
        sat_o   = 1'b0;
        clamped = diff_i;
        if (diff_i > AMP_MAX_S) begin
            clamped = AMP_MAX_S;
            sat_o   = 1'b1;
        end else if (diff_i < -AMP_MAX_S) begin
            clamped = -AMP_MAX_S;
            sat_o   = 1'b1;
        end
        val         = VAL_W'(clamped);
        mag         = AMP_W'(val[VAL_W-1] ? -val : val);
        cat         = dc_category(mag);
        amp_bits_o  = dc_amp_bits(val, cat);
        amp_len_o   = cat;
        huff_code_o = is_luma_i ? LUMA_DC_CODE[cat] : CHROMA_DC_CODE[cat];
        huff_len_o  = is_luma_i ? LUMA_DC_LEN[cat]  : CHROMA_DC_LEN[cat];
    end

endmodule

// File: rtl/huffman_dc_dpcm_enc.sv
// Multi-channel DC DPCM + Huffman encoder: predictor/difference stage, then registered code lookup.
module huffman_dc_dpcm_enc
    import jpeg_huff_pkg::*;
#(
    parameter int unsigned       DC_W      = 12,
    parameter int unsigned       NUM_CH    = 3,
    parameter logic [NUM_CH-1:0] LUMA_MASK = NUM_CH'(1),
    parameter int unsigned       CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   restart,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [DC_W-1:0] dc_in,
    input  logic [CH_W-1:0]        ch_id,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CODE_W-1:0]      huff_code,
    output logic [LEN_W-1:0]       huff_len,
    output logic [AMP_W-1:0]       amp_bits,
    output logic [CAT_W-1:0]       amp_len,
    output logic                   sat
);

    localparam int unsigned     DIFF_W  = DC_W + 1;
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

    logic signed [DC_W-1:0]   pred_q [NUM_CH];
    logic signed [DC_W-1:0]   pred_d [NUM_CH];
    logic                     s1_valid_q, s1_valid_d;
    logic signed [DIFF_W-1:0] s1_diff_q, s1_diff_d;
    logic                     s1_luma_q, s1_luma_d;
    logic                     out_valid_q, out_valid_d;
    logic [CODE_W-1:0]        huff_code_q, huff_code_d;
    logic [LEN_W-1:0]         huff_len_q, huff_len_d;
    logic [AMP_W-1:0]         amp_bits_q, amp_bits_d;
    logic [CAT_W-1:0]         amp_len_q, amp_len_d;
    logic                     sat_q, sat_d;

    logic                     advance;
    logic                     accept;
    logic [CH_W-1:0]          ch_sel;
    logic signed [DC_W-1:0]   pred_sel;
    logic [CODE_W-1:0]        enc_code;
    logic [LEN_W-1:0]         enc_len;
    logic [AMP_W-1:0]         enc_amp;
    logic [CAT_W-1:0]         enc_amp_len;
    logic                     enc_sat;

    dc_category_huff #(
        .DIFF_W (DIFF_W)
    ) u_cat (
        .diff_i      (s1_diff_q),
        .is_luma_i   (s1_luma_q),
        .huff_code_o (enc_code),
        .huff_len_o  (enc_len),
        .amp_bits_o  (enc_amp),
        .amp_len_o   (enc_amp_len),
        .sat_o       (enc_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CH); i++) pred_q[i] <= '0;
            s1_valid_q  <= 1'b0;
            s1_diff_q   <= '0;
            s1_luma_q   <= 1'b0;
            out_valid_q <= 1'b0;
            huff_code_q <= '0;
            huff_len_q  <= '0;
            amp_bits_q  <= '0;
            amp_len_q   <= '0;
            sat_q       <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) pred_q[i] <= pred_d[i];
            s1_valid_q  <= s1_valid_d;
            s1_diff_q   <= s1_diff_d;
            s1_luma_q   <= s1_luma_d;
            out_valid_q <= out_valid_d;
            huff_code_q <= huff_code_d;
            huff_len_q  <= huff_len_d;
            amp_bits_q  <= amp_bits_d;
            amp_len_q   <= amp_len_d;
            sat_q       <= sat_d;
        end
    end

    // Stage 1 may fill while the output is stalled if it is empty; stage 2 moves only on advance.
    always_comb begin
        advance  = !out_valid_q || out_ready;
        in_ready = advance || !s1_valid_q;
        accept   = in_valid && in_ready;
        ch_sel   = (32'(ch_id) >= NUM_CH) ? CH_LAST : ch_id;
        pred_sel = restart ? '0 : pred_q[ch_sel];

        for (int i = 0; i < int'(NUM_CH); i++) pred_d[i] = restart ? '0 : pred_q[i];
        if (accept) pred_d[ch_sel] = dc_in;

        s1_valid_d = s1_valid_q;
        s1_diff_d  = s1_diff_q;
        s1_luma_d  = s1_luma_q;
        if (in_ready) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_diff_d = DIFF_W'(dc_in) - DIFF_W'(pred_sel);
                s1_luma_d = LUMA_MASK[ch_sel];
            end
        end

        out_valid_d = out_valid_q;
        huff_code_d = huff_code_q;
        huff_len_d  = huff_len_q;
        amp_bits_d  = amp_bits_q;
        amp_len_d   = amp_len_q;
        sat_d       = sat_q;
        if (advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                huff_code_d = enc_code;
                huff_len_d  = enc_len;
                amp_bits_d  = enc_amp;
                amp_len_d   = enc_amp_len;
                sat_d       = enc_sat;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign huff_code = huff_code_q;
    assign huff_len  = huff_len_q;
    assign amp_bits  = amp_bits_q;
    assign amp_len   = amp_len_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_huffman_dc_dpcm_enc.sv
// Bench for huffman_dc_dpcm_enc: directed scenarios plus random traffic against a queue-based model.
module tb_huffman_dc_dpcm_enc;

    logic               clk = 1'b0;
    logic               rst;
    logic               restart;
    logic               in_valid;
    logic               in_ready;
    logic signed [11:0] dc_in;
    logic [1:0]         ch_id;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        huff_code;
    logic [4:0]         huff_len;
    logic [10:0]        amp_bits;
    logic [3:0]         amp_len;
    logic               sat;

    always #5 clk = ~clk;

    huffman_dc_dpcm_enc dut (
        .clk       (clk),
        .rst       (rst),
        .restart   (restart),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dc_in     (dc_in),
        .ch_id     (ch_id),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .huff_code (huff_code),
        .huff_len  (huff_len),
        .amp_bits  (amp_bits),
        .amp_len   (amp_len),
        .sat       (sat)
    );

    typedef struct {
        int code;
        int len;
        int amp;
        int alen;
        int sat;
    } exp_t;

    string luma_tab [12] = '{"00", "010", "011", "100", "101", "110", "1110", "11110",
                             "111110", "1111110", "11111110", "111111110"};
    string chroma_tab [12] = '{"00", "01", "10", "110", "1110", "11110", "111110", "1111110",
                               "11111110", "111111110", "1111111110", "11111111110"};

    int   n_checks = 0;
    int   n_errors = 0;
    int   pred [3];
    exp_t exp_q [$];
    exp_t mon_e;
    int   mon_c;
    int   mon_p;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Reference encoding straight from the JPEG rules: clamp, bit length, code string lookup.
    function automatic exp_t model_enc(input int diff, input bit luma);
        exp_t  e;
        int    d;
        int    mag;
        int    cat;
        string s;
        d     = diff;
        e.sat = 0;
        if (d > 2047) begin
            d = 2047;
            e.sat = 1;
        end else if (d < -2047) begin
            d = -2047;
            e.sat = 1;
        end
        mag = (d < 0) ? -d : d;
        cat = 0;
        while ((1 << cat) <= mag) cat++;
        s      = luma ? luma_tab[cat] : chroma_tab[cat];
        e.len  = s.len();
        e.code = 0;
        for (int i = 0; i < s.len(); i++) e.code = (e.code << 1) | ((s[i] == "1") ? 1 : 0);
        e.alen = cat;
        if (d > 0)      e.amp = d;
        else if (d < 0) e.amp = d + (1 << cat) - 1;
        else            e.amp = 0;
        return e;
    endfunction

    // Scoreboard: outputs checked whenever valid (so stalls must hold), popped on transfer.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < 3; i++) pred[i] = 0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("stray_out", 32'(out_valid), 0);
                end else begin
                    mon_e = exp_q[0];
                    check("sb_code", 32'(huff_code), mon_e.code);
                    check("sb_len",  32'(huff_len),  mon_e.len);
                    check("sb_amp",  32'(amp_bits),  mon_e.amp);
                    check("sb_alen", 32'(amp_len),   mon_e.alen);
                    check("sb_sat",  32'(sat),       mon_e.sat);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                mon_c = int'(ch_id);
                if (mon_c >= 3) mon_c = 2;
                mon_p = restart ? 0 : pred[mon_c];
                if (restart) for (int i = 0; i < 3; i++) pred[i] = 0;
                pred[mon_c] = int'(dc_in);
                exp_q.push_back(model_enc(int'(dc_in) - mon_p, mon_c == 0));
            end else if (restart) begin
                for (int i = 0; i < 3; i++) pred[i] = 0;
            end
        end
    end

    task automatic send(input int ch, input int dc, input bit rs);
        bit done;
        done     = 1'b0;
        ch_id    = 2'(ch);
        dc_in    = 12'(dc);
        restart  = rs;
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
        end
        if (!done) check("send_timeout", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        restart  = 1'b0;
    endtask

    task automatic check_fields(input string tag, input int code, input int len,
                                input int amp, input int alen, input int s);
        check({tag, "_code"}, 32'(huff_code), code);
        check({tag, "_len"},  32'(huff_len),  len);
        check({tag, "_amp"},  32'(amp_bits),  amp);
        check({tag, "_alen"}, 32'(amp_len),   alen);
        check({tag, "_sat"},  32'(sat),       s);
    endtask

    task automatic expect_out(input string tag, input int code, input int len,
                              input int amp, input int alen, input int s);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        if (!seen) check({tag, "_timeout"}, 32'(out_valid), 1);
        else       check_fields(tag, code, len, amp, alen, s);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        restart   = 1'b0;
        in_valid  = 1'b0;
        dc_in     = '0;
        ch_id     = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check_fields("rst", 0, 0, 0, 0, 0);
        check("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        // Basic luma differences and exact two-cycle latency.
        send(0, 5, 1'b0);
        @(negedge clk);
        check("lat_n1_valid", 32'(out_valid), 0);
        @(negedge clk);
        check("lat_n2_valid", 32'(out_valid), 1);
        check_fields("pos5", 4, 3, 5, 3, 0);
        send(0, 3, 1'b0);
        expect_out("neg2", 3, 3, 1, 2, 0);

        // Chroma channel, largest category, and independent ch0 predictor.
        send(1, 0, 1'b0);
        expect_out("ch1_zero", 0, 2, 0, 0, 0);
        send(1, -1024, 1'b0);
        expect_out("ch1_m1024", 16'h7FE, 11, 16'h3FF, 11, 0);
        send(0, 3, 1'b0);
        expect_out("ch0_same", 0, 2, 0, 0, 0);

        // Clamping at both ends.
        do_reset();
        send(0, -2048, 1'b0);
        expect_out("clamp_neg", 16'h1FE, 9, 0, 11, 1);
        send(0, 2047, 1'b0);
        expect_out("clamp_pos", 16'h1FE, 9, 16'h7FF, 11, 1);

        // Back-pressure: both stages fill, third sample waits without touching the predictor.
        do_reset();
        out_ready = 1'b0;
        send(0, 10, 1'b0);
        send(0, 20, 1'b0);
        ch_id    = 2'd0;
        dc_in    = 12'sd30;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 0);
            check_fields("stall_hold", 5, 3, 10, 4, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(0, 30, 1'b0);
        repeat (4) @(negedge clk);
        check("stall_drained", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1;

        // Restart alone and restart coinciding with an accept.
        do_reset();
        send(2, 7, 1'b0);
        expect_out("rs_first", 6, 3, 7, 3, 0);
        @(posedge clk);
        #1;
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        send(2, 7, 1'b0);
        expect_out("rs_alone", 6, 3, 7, 3, 0);
        send(2, 4, 1'b1);
        expect_out("rs_accept", 6, 3, 4, 3, 0);
        send(2, 4, 1'b0);
        expect_out("rs_pred4", 0, 2, 0, 0, 0);

        // Reset with two samples in flight.
        @(posedge clk);
        #1;
        send(0, 100, 1'b0);
        send(0, 200, 1'b0);
        do_reset();
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 0);
        check_fields("mid_rst", 0, 0, 0, 0, 0);
        check("mid_rst_in_ready", 32'(in_ready), 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_rst_no_stray", 32'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        send(0, 1, 1'b0);
        expect_out("post_rst", 2, 3, 1, 1, 0);
        @(posedge clk);
        #1;

        // Random traffic, including out-of-range channel ids and sporadic restarts.
        for (int n = 0; n < 800; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            ch_id     = 2'($urandom_range(0, 3));
            dc_in     = ($urandom_range(0, 1) != 0) ? 12'($urandom)
                                                     : 12'(int'($urandom_range(0, 16)) - 8);
            restart   = ($urandom_range(0, 31) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        restart   = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("rand_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
